// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT/IFFT frame sequencer.
// State encoding, error bit positions and core config words.
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LOAD,
    S_MULT,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_TLAST   = 1;
  localparam int ERR_OVERRUN = 2;

  localparam logic [7:0] CFG_FWD = 8'h01;
  localparam logic [7:0] CFG_INV = 8'h00;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register for valid/last sideband bits.
// Synchronous clear flushes in-flight beats on abort.
module valid_delay_line #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] sr;

  // shift one stage per cycle, flush on reset or clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fft_ifft_seq_ctrl.sv
// Frame sequencer: ADC -> FFT -> spectrum multiply -> IFFT -> DAC.
// Configures both cores, frames samples, tracks output frames.
module fft_ifft_seq_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int N_LOG2   = 10,
  parameter int CMPY_LAT = 6,
  parameter int TIMEOUT  = 65535
) (
  input  logic              fft_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              adc_valid,
  output logic              fft_cfg_tvalid,
  output logic [7:0]        fft_cfg_tdata,
  input  logic              fft_cfg_tready,
  output logic              ifft_cfg_tvalid,
  output logic [7:0]        ifft_cfg_tdata,
  input  logic              ifft_cfg_tready,
  output logic              fft_s_tvalid,
  output logic              fft_s_tlast,
  input  logic              fft_s_tready,
  input  logic              fft_m_tvalid,
  input  logic              fft_m_tlast,
  output logic              fft_m_tready,
  output logic              ram_rd_en,
  output logic [N_LOG2-1:0] ram_rd_addr,
  output logic              cmpy_valid,
  output logic              ifft_s_tvalid,
  output logic              ifft_s_tlast,
  input  logic              ifft_s_tready,
  input  logic              ifft_m_tvalid,
  input  logic              ifft_m_tlast,
  output logic              dac_valid,
  output logic [N_LOG2-1:0] dac_index,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [N_LOG2-1:0] LAST = '1;

  state_t            state;
  logic [N_LOG2-1:0] in_cnt;
  logic [N_LOG2-1:0] out_cnt;
  logic [N_LOG2-1:0] dac_cnt;
  logic [WD_W-1:0]   wd;
  logic              tlast_q;

  logic s_load, s_mult, s_drain;
  logic s_acc, wd_on, timeout;
  logic fft_cfg_ok, ifft_cfg_ok;

  assign s_load  = (state == S_LOAD);
  assign s_mult  = (state == S_MULT);
  assign s_drain = (state == S_DRAIN);

  assign fft_cfg_tdata  = CFG_FWD;
  assign ifft_cfg_tdata = CFG_INV;

  assign fft_s_tvalid = adc_valid & s_load;
  assign fft_s_tlast  = fft_s_tvalid & (in_cnt == LAST);
  assign s_acc        = fft_s_tvalid & fft_s_tready;

  assign fft_m_tready = s_mult;
  assign ram_rd_en    = fft_m_tvalid & s_mult;
  assign ram_rd_addr  = ram_rd_en ? out_cnt : '0;

  assign dac_valid = ifft_m_tvalid & (s_mult | s_drain);
  assign dac_index = dac_cnt;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  assign wd_on   = s_load | s_mult | s_drain;
  assign timeout = wd_on & (wd == WD_LAST);

  assign fft_cfg_ok  = !fft_cfg_tvalid | fft_cfg_tready;
  assign ifft_cfg_ok = !ifft_cfg_tvalid | ifft_cfg_tready;

  // frame state machine, counters, watchdog and sticky errors
  always_ff @(posedge fft_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state           <= S_IDLE;
      fft_cfg_tvalid  <= 1'b0;
      ifft_cfg_tvalid <= 1'b0;
      in_cnt          <= '0;
      out_cnt         <= '0;
      dac_cnt         <= '0;
      wd              <= '0;
      err             <= '0;
    end else begin
      if (abort || timeout) begin
        state           <= S_IDLE;
        fft_cfg_tvalid  <= 1'b0;
        ifft_cfg_tvalid <= 1'b0;
        in_cnt          <= '0;
        out_cnt         <= '0;
        dac_cnt         <= '0;
        wd              <= '0;
        if (timeout) err[ERR_TIMEOUT] <= 1'b1;
      end else begin
        if (dac_valid) dac_cnt <= dac_cnt + 1'b1;
        wd <= wd_on ? wd + 1'b1 : '0;
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state           <= S_CFG;
              fft_cfg_tvalid  <= 1'b1;
              ifft_cfg_tvalid <= 1'b1;
              in_cnt          <= '0;
              out_cnt         <= '0;
              dac_cnt         <= '0;
              err             <= '0;
            end
          end
          S_CFG: begin
            if (fft_cfg_tready) fft_cfg_tvalid <= 1'b0;
            if (ifft_cfg_tready) ifft_cfg_tvalid <= 1'b0;
            if (fft_cfg_ok && ifft_cfg_ok) begin
              state <= S_LOAD;
              wd    <= '0;
            end
          end
          S_LOAD: begin
            if (s_acc) begin
              in_cnt <= in_cnt + 1'b1;
              if (in_cnt == LAST) begin
                state <= S_MULT;
                wd    <= '0;
              end
            end
          end
          S_MULT: begin
            if (ram_rd_en) begin
              out_cnt <= out_cnt + 1'b1;
              if (fft_m_tlast != (out_cnt == LAST)) begin
                err[ERR_TLAST] <= 1'b1;
              end
              if (out_cnt == LAST) begin
                state <= S_DRAIN;
                wd    <= '0;
              end
            end
          end
          S_DRAIN: begin
            if (ifft_m_tvalid && ifft_m_tlast) begin
              state <= S_DONE;
              wd    <= '0;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
      if (ifft_s_tvalid && !ifft_s_tready) err[ERR_OVERRUN] <= 1'b1;
    end
  end

  // align multiplier valid and tlast with the 1-cycle RAM read
  always_ff @(posedge fft_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cmpy_valid <= 1'b0;
      tlast_q    <= 1'b0;
    end else if (abort) begin
      cmpy_valid <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      cmpy_valid <= fft_m_tvalid & fft_m_tready;
      tlast_q    <= fft_m_tvalid & fft_m_tready & fft_m_tlast;
    end
  end

  valid_delay_line #(
    .DEPTH(CMPY_LAT),
    .WIDTH(2)
  ) u_dly (
    .clk (fft_clk),
    .rst (sys_rst),
    .clr (abort),
    .din ({tlast_q, cmpy_valid}),
    .dout({ifft_s_tlast, ifft_s_tvalid})
  );

endmodule
